// File: rtl/stateful_array_processor_arbiter_pkg.sv
// Shared definitions for the stateful array processor arbiter: FSM state
// encoding, the requester-ID width helper and the drop-counter ceiling.
package stateful_array_processor_arbiter_pkg;

  localparam logic [1:0] ST_IDLE_C        = 2'd0;
  localparam logic [1:0] ST_STREAM_C      = 2'd1;
  localparam logic [1:0] ST_WAIT_RESULT_C = 2'd2;
  localparam logic [1:0] ST_DELIVER_C     = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE        = ST_IDLE_C,
    ST_STREAM      = ST_STREAM_C,
    ST_WAIT_RESULT = ST_WAIT_RESULT_C,
    ST_DELIVER     = ST_DELIVER_C
  } state_t;

  localparam logic [15:0] DROP_MAX_C = 16'hFFFF;

  // Requester ID width; never narrower than one bit.
  function automatic int idw_f(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/stateful_array_processor_arbiter_if.sv
// Bundle of requester, processor and result-side signals around the arbiter.
// master = the arbiter itself, slave = the surrounding environment.
interface stateful_array_processor_arbiter_if
  import stateful_array_processor_arbiter_pkg::*;
#(
  parameter int NUM_REQUESTERS     = 4,
  parameter int REPLICATION_FACTOR = 3,
  parameter int RESULT_WIDTH       = 96
);
  localparam int DW  = 8 * REPLICATION_FACTOR;
  localparam int IDW = idw_f(NUM_REQUESTERS);

  logic [NUM_REQUESTERS*DW-1:0] req_data;
  logic [NUM_REQUESTERS-1:0]    req_valid;
  logic [NUM_REQUESTERS-1:0]    req_last;
  logic [NUM_REQUESTERS-1:0]    req_ready;
  logic                         p_enable;
  logic [DW-1:0]                p_in_data;
  logic                         p_in_valid;
  logic                         p_in_last;
  logic                         p_in_ready;
  logic [RESULT_WIDTH-1:0]      p_out_data;
  logic                         p_out_valid;
  logic [RESULT_WIDTH-1:0]      res_data;
  logic [IDW-1:0]               res_id;
  logic                         res_error;
  logic                         res_valid;
  logic                         res_ready;
  logic [15:0]                  dropped_results;

  modport master (
    input  req_data, req_valid, req_last, p_in_ready, p_out_data, p_out_valid, res_ready,
    output req_ready, p_enable, p_in_data, p_in_valid, p_in_last,
           res_data, res_id, res_error, res_valid, dropped_results
  );

  modport slave (
    output req_data, req_valid, req_last, p_in_ready, p_out_data, p_out_valid, res_ready,
    input  req_ready, p_enable, p_in_data, p_in_valid, p_in_last,
           res_data, res_id, res_error, res_valid, dropped_results
  );

endinterface

// File: rtl/stateful_array_processor_arbiter_rr_priority_picker.sv
// Round-robin priority picker: first requesting index at or above ptr,
// otherwise the first requesting index below it (wrap-around).
module rr_priority_picker
  import stateful_array_processor_arbiter_pkg::*;
#(
  parameter int  NUM_REQUESTERS = 4,
  localparam int IDW            = idw_f(NUM_REQUESTERS)
) (
  input  logic [NUM_REQUESTERS-1:0] req,
  input  logic [IDW-1:0]            ptr,
  output logic [NUM_REQUESTERS-1:0] grant_oh,
  output logic [IDW-1:0]            grant_idx,
  output logic                      grant_any
);

  // Two passes: upper segment [ptr..N-1] first, then the wrapped segment.
  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int i = 0; i < NUM_REQUESTERS; i++) begin
      if (!grant_any && req[i] && (IDW'(i) >= ptr)) begin
        grant_oh[i] = 1'b1;
        grant_idx   = IDW'(i);
        grant_any   = 1'b1;
      end else begin
        grant_any = grant_any;
      end
    end
    for (int i = 0; i < NUM_REQUESTERS; i++) begin
      if (!grant_any && req[i]) begin
        grant_oh[i] = 1'b1;
        grant_idx   = IDW'(i);
        grant_any   = 1'b1;
      end else begin
        grant_any = grant_any;
      end
    end
  end

endmodule

// File: rtl/stateful_array_processor_arbiter.sv
// Frame-granular round-robin arbiter sharing one count-min sketch processor
// between several byte-lane streams. One whole frame is forwarded at a time,
// the processor's single-cycle result pulse is captured and handed back
// tagged with the owning requester ID.
module stateful_array_processor_arbiter
  import stateful_array_processor_arbiter_pkg::*;
#(
  parameter int NUM_REQUESTERS     = 4,
  parameter int REPLICATION_FACTOR = 3,
  parameter int RESULT_WIDTH       = 96,
  parameter int RESULT_TIMEOUT     = 255
) (
  input logic                               clock,
  input logic                               reset,
  stateful_array_processor_arbiter_if.master bus
);

  localparam int DW  = 8 * REPLICATION_FACTOR;
  localparam int IDW = idw_f(NUM_REQUESTERS);
  localparam int WCW = $clog2(RESULT_TIMEOUT + 1);

  state_t                    state_r;
  logic [IDW-1:0]            grant_r;
  logic [NUM_REQUESTERS-1:0] grant_oh_r;
  logic [IDW-1:0]            rr_ptr_r;
  logic [WCW-1:0]            wait_cnt_r;
  logic [RESULT_WIDTH-1:0]   res_data_r;
  logic [IDW-1:0]            res_id_r;
  logic                      res_error_r;
  logic                      res_valid_r;
  logic [15:0]               dropped_r;

  logic [NUM_REQUESTERS-1:0] pick_oh_s;
  logic [IDW-1:0]            pick_idx_s;
  logic                      pick_any_s;
  logic [DW-1:0]             sel_data_s;
  logic                      sel_valid_s;
  logic                      sel_last_s;
  logic                      stream_s;
  logic                      last_fire_s;
  logic [IDW-1:0]            next_ptr_s;

  rr_priority_picker #(.NUM_REQUESTERS(NUM_REQUESTERS)) u_picker (
    .req       (bus.req_valid),
    .ptr       (rr_ptr_r),
    .grant_oh  (pick_oh_s),
    .grant_idx (pick_idx_s),
    .grant_any (pick_any_s)
  );

  // Select the granted requester's beat, valid and last.
  always_comb begin
    sel_data_s  = '0;
    sel_valid_s = 1'b0;
    sel_last_s  = 1'b0;
    for (int i = 0; i < NUM_REQUESTERS; i++) begin
      if (grant_r == IDW'(i)) begin
        sel_data_s  = bus.req_data[i*DW +: DW];
        sel_valid_s = bus.req_valid[i];
        sel_last_s  = bus.req_last[i];
      end else begin
        sel_valid_s = sel_valid_s;
      end
    end
  end

  // The forward path is combinational so STREAM keeps one beat per cycle.
  assign stream_s       = (state_r == ST_STREAM);
  assign last_fire_s    = stream_s & sel_valid_s & bus.p_in_ready & sel_last_s;
  assign next_ptr_s     = (grant_r == IDW'(NUM_REQUESTERS - 1)) ? '0 : grant_r + IDW'(1);
  assign bus.p_in_data  = stream_s ? sel_data_s : '0;
  assign bus.p_in_valid = stream_s & sel_valid_s;
  assign bus.p_in_last  = stream_s & sel_last_s;
  assign bus.req_ready  = (stream_s && bus.p_in_ready) ? grant_oh_r : '0;
  assign bus.p_enable   = (state_r == ST_STREAM) || (state_r == ST_WAIT_RESULT);

  assign bus.res_data        = res_data_r;
  assign bus.res_id          = res_id_r;
  assign bus.res_error       = res_error_r;
  assign bus.res_valid       = res_valid_r;
  assign bus.dropped_results = dropped_r;

  // Arbitration FSM, result capture/timeout and the unexpected-pulse counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      grant_r     <= '0;
      grant_oh_r  <= '0;
      rr_ptr_r    <= '0;
      wait_cnt_r  <= '0;
      res_data_r  <= '0;
      res_id_r    <= '0;
      res_error_r <= 1'b0;
      res_valid_r <= 1'b0;
      dropped_r   <= 16'd0;
    end else begin
      if (bus.p_out_valid && (state_r != ST_WAIT_RESULT) && (dropped_r != DROP_MAX_C)) begin
        dropped_r <= dropped_r + 16'd1;
      end else begin
        dropped_r <= dropped_r;
      end

      case (state_r)
        ST_IDLE: begin
          if (pick_any_s) begin
            grant_r    <= pick_idx_s;
            grant_oh_r <= pick_oh_s;
            state_r    <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (last_fire_s) begin
            wait_cnt_r <= '0;
            state_r    <= ST_WAIT_RESULT;
          end
        end
        ST_WAIT_RESULT: begin
          // A pulse in the final timeout cycle still counts as a good result.
          if (bus.p_out_valid) begin
            res_data_r  <= bus.p_out_data;
            res_error_r <= 1'b0;
            res_id_r    <= grant_r;
            res_valid_r <= 1'b1;
            wait_cnt_r  <= '0;
            state_r     <= ST_DELIVER;
          end else if (wait_cnt_r == WCW'(RESULT_TIMEOUT - 1)) begin
            res_data_r  <= '0;
            res_error_r <= 1'b1;
            res_id_r    <= grant_r;
            res_valid_r <= 1'b1;
            wait_cnt_r  <= '0;
            state_r     <= ST_DELIVER;
          end else begin
            wait_cnt_r  <= wait_cnt_r + WCW'(1);
          end
        end
        ST_DELIVER: begin
          if (bus.res_ready) begin
            res_valid_r <= 1'b0;
            rr_ptr_r    <= next_ptr_s;
            state_r     <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stateful_array_processor_arbiter.sv
// Bench for stateful_array_processor_arbiter: directed scenarios plus random
// frames, all checked against a frame-level round-robin model.
module tb_stateful_array_processor_arbiter;

  localparam int N   = 4;
  localparam int RF  = 3;
  localparam int DW  = 8 * RF;
  localparam int RW  = 96;
  localparam int TMO = 8;

  logic clock;
  logic reset;

  int n_checks;
  int n_fail;
  int m_ptr;
  int m_dropped;

  logic [DW-1:0] beat_data [N][8];
  int            pos [N];
  int            len [N];
  bit            act [N];

  stateful_array_processor_arbiter_if #(
    .NUM_REQUESTERS(N), .REPLICATION_FACTOR(RF), .RESULT_WIDTH(RW)
  ) bus ();

  stateful_array_processor_arbiter #(
    .NUM_REQUESTERS(N), .REPLICATION_FACTOR(RF), .RESULT_WIDTH(RW), .RESULT_TIMEOUT(TMO)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Round-robin reference: first pending requester at ptr, ptr+1, ... mod N.
  function automatic int model_pick(input int ptr);
    for (int k = 0; k < N; k++) begin
      if (act[(ptr + k) % N]) return (ptr + k) % N;
    end
    return 0;
  endfunction

  task automatic drive_reqs(input int g, input bit gap);
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i]         = act[i] && !(gap && (i == g));
      bus.req_last[i]          = act[i] && (pos[i] == len[i] - 1);
      bus.req_data[i*DW +: DW] = act[i] ? beat_data[i][pos[i]] : '0;
    end
  endtask

  task automatic activate(input int i, input int l);
    if (!act[i]) begin
      act[i] = 1'b1;
      pos[i] = 0;
      len[i] = (l > 0) ? l : int'($urandom_range(1, 5));
      for (int b = 0; b < 8; b++) beat_data[i][b] = DW'($urandom);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_req_ready"},  RW'(bus.req_ready),       '0);
    chk({tag, "_p_enable"},   RW'(bus.p_enable),        '0);
    chk({tag, "_p_in_valid"}, RW'(bus.p_in_valid),      '0);
    chk({tag, "_p_in_last"},  RW'(bus.p_in_last),       '0);
    chk({tag, "_p_in_data"},  RW'(bus.p_in_data),       '0);
    chk({tag, "_res_valid"},  RW'(bus.res_valid),       '0);
    chk({tag, "_res_id"},     RW'(bus.res_id),          '0);
    chk({tag, "_res_error"},  RW'(bus.res_error),       '0);
    chk({tag, "_res_data"},   bus.res_data,             '0);
    chk({tag, "_dropped"},    RW'(bus.dropped_results), '0);
  endtask

  // One complete frame: idle cycle, stream, wait for result, deliver.
  // dly > TMO means the processor never answers.
  task automatic run_frame(input logic [N-1:0] mask, input int flen, input int dly,
                           input logic [RW-1:0] pdata, input int hold, input bit spur);
    int g;
    int guard;
    int w;
    bit gap;
    bit rdy;
    bit fire;
    bit err;
    logic [RW-1:0] exp_data;
    for (int i = 0; i < N; i++) if (mask[i]) activate(i, flen);
    bus.p_in_ready  = 1'b1;
    bus.res_ready   = 1'b0;
    bus.p_out_valid = 1'b0;
    drive_reqs(-1, 1'b0);
    #1;
    chk("idle_req_ready", RW'(bus.req_ready), '0);
    chk("idle_p_enable",  RW'(bus.p_enable),  '0);
    chk("idle_res_valid", RW'(bus.res_valid), '0);
    g = model_pick(m_ptr);
    tick();
    guard = 0;
    while (pos[g] < len[g] && guard < 200) begin
      gap = ($urandom_range(0, 3) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      drive_reqs(g, gap);
      bus.p_in_ready = rdy;
      #1;
      chk("stream_req_ready",  RW'(bus.req_ready), rdy ? (RW'(1) << g) : '0);
      chk("stream_p_enable",   RW'(bus.p_enable), RW'(1));
      chk("stream_p_in_valid", RW'(bus.p_in_valid), RW'(!gap));
      if (!gap) begin
        chk("stream_p_in_data", RW'(bus.p_in_data), RW'(beat_data[g][pos[g]]));
        chk("stream_p_in_last", RW'(bus.p_in_last), RW'(pos[g] == len[g] - 1));
      end
      fire = !gap && rdy;
      tick();
      if (fire) pos[g]++;
      guard++;
    end
    act[g] = 1'b0;
    drive_reqs(-1, 1'b0);
    bus.p_in_ready = 1'b1;
    w        = (dly < TMO) ? dly : TMO;
    err      = (dly > TMO);
    exp_data = err ? '0 : pdata;
    for (int k = 1; k <= w; k++) begin
      bus.p_out_valid = (k == dly);
      bus.p_out_data  = (k == dly) ? pdata : {$urandom, $urandom, $urandom};
      #1;
      chk("wait_res_valid", RW'(bus.res_valid), '0);
      chk("wait_req_ready", RW'(bus.req_ready), '0);
      chk("wait_p_enable",  RW'(bus.p_enable),  RW'(1));
      tick();
    end
    bus.p_out_valid = 1'b0;
    for (int h = 0; h <= hold; h++) begin
      bus.res_ready   = (h == hold);
      bus.p_out_valid = spur && (h == 0);
      if (spur && (h == 0)) m_dropped++;
      #1;
      chk("deliver_res_valid", RW'(bus.res_valid), RW'(1));
      chk("deliver_res_id",    RW'(bus.res_id),    RW'(g));
      chk("deliver_res_data",  bus.res_data,       exp_data);
      chk("deliver_res_error", RW'(bus.res_error), RW'(err));
      chk("deliver_req_ready", RW'(bus.req_ready), '0);
      chk("deliver_p_enable",  RW'(bus.p_enable),  '0);
      tick();
      bus.p_out_valid = 1'b0;
    end
    bus.res_ready = 1'b0;
    m_ptr = (g + 1) % N;
    chk("dropped_results", RW'(bus.dropped_results), RW'(m_dropped));
  endtask

  initial begin
    int g;
    n_checks  = 0;
    n_fail    = 0;
    m_ptr     = 0;
    m_dropped = 0;
    for (int i = 0; i < N; i++) begin
      act[i] = 1'b0;
      pos[i] = 0;
      len[i] = 1;
    end
    reset           = 1'b0;
    bus.req_data    = '0;
    bus.req_valid   = '0;
    bus.req_last    = '0;
    bus.p_in_ready  = 1'b0;
    bus.p_out_data  = '0;
    bus.p_out_valid = 1'b0;
    bus.res_ready   = 1'b0;
    repeat (2) tick();
    chk_zero("por");
    reset = 1'b1;

    // Single requester 2, four beats, result 0xABC three cycles later.
    run_frame(4'b0100, 4, 3, 96'hABC, 0, 1'b0);

    // Fairness: everyone pending with two-beat frames; order starts at 3.
    for (int f = 0; f < 8; f++) run_frame(4'hF, 2, 2, {$urandom, $urandom, $urandom}, 0, 1'b0);

    // Result backpressure for ten cycles with another requester pending.
    run_frame(4'b1100, 0, 2, {$urandom, $urandom, $urandom}, 10, 1'b0);

    // Timeout with no pulse, then a pulse coincident with the last wait cycle.
    run_frame(4'b0001, 0, 100, {$urandom, $urandom, $urandom}, 1, 1'b0);
    run_frame(4'b0001, 0, TMO, {$urandom, $urandom, $urandom}, 0, 1'b0);

    // Spurious pulses while idle.
    for (int i = 0; i < N; i++) act[i] = 1'b0;
    drive_reqs(-1, 1'b0);
    for (int s = 0; s < 3; s++) begin
      bus.p_out_valid = 1'b1;
      bus.p_out_data  = {$urandom, $urandom, $urandom};
      #1;
      chk("spur_res_valid", RW'(bus.res_valid), '0);
      tick();
      bus.p_out_valid = 1'b0;
      m_dropped++;
      #1;
      chk("spur_p_enable", RW'(bus.p_enable), '0);
      tick();
    end
    chk("spur_dropped", RW'(bus.dropped_results), RW'(3));
    chk("spur_res_valid_after", RW'(bus.res_valid), '0);

    // Random frames.
    for (int r = 0; r < 30; r++) begin
      run_frame(4'($urandom_range(1, 15)), 0, int'($urandom_range(1, 10)),
                {$urandom, $urandom, $urandom}, int'($urandom_range(0, 3)),
                bit'($urandom_range(0, 1)));
    end

    // Reset during beat 2: requester 1 leaves rr_ptr at 2, so 3 wins first.
    for (int i = 0; i < N; i++) act[i] = 1'b0;
    run_frame(4'b0010, 0, 2, {$urandom, $urandom, $urandom}, 0, 1'b0);
    activate(1, 4);
    activate(3, 4);
    bus.p_in_ready = 1'b1;
    drive_reqs(-1, 1'b0);
    g = model_pick(m_ptr);
    tick();
    drive_reqs(g, 1'b0);
    #1;
    chk("rst_beat1_req_ready", RW'(bus.req_ready), RW'(1) << g);
    tick();
    pos[g]++;
    drive_reqs(g, 1'b0);
    #1;
    chk("rst_beat2_p_in_data", RW'(bus.p_in_data), RW'(beat_data[g][pos[g]]));
    reset = 1'b0;
    #1;
    chk_zero("midframe");
    m_ptr     = 0;
    m_dropped = 0;
    for (int i = 0; i < N; i++) pos[i] = 0;
    tick();
    reset = 1'b1;
    run_frame(4'b1010, 4, 3, {$urandom, $urandom, $urandom}, 0, 1'b0);
    run_frame(4'b0000, 4, 3, {$urandom, $urandom, $urandom}, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stateful_array_processor_arbiter.md
# stateful_array_processor_arbiter

Frame-granular round-robin arbiter that shares one high-throughput stateful array processor (count-min sketch datapath) between NUM_REQUESTERS independent byte-lane streams. It grants one whole frame at a time, forwards its beats to the processor, captures the processor's single-cycle result pulse, and returns the result tagged with the requester ID. It sits between the per-port stream demux and the processor instance.

## Interface
- NUM_REQUESTERS, 4: number of requesters, ≥2; ID width IDW = max(1, clog2(NUM_REQUESTERS)).
- REPLICATION_FACTOR, 3: bytes per beat; DW = 8*REPLICATION_FACTOR.
- RESULT_WIDTH, 96: processor result width, ARRAY_WIDTH*ARRAY_HEIGHT*CELL_WIDTH.
- RESULT_TIMEOUT, 255: maximum WAIT_RESULT cycles before an error result, ≥1.

Ports:
- clock  in  1  single clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_data  in  NUM_REQUESTERS*DW  per-requester beat data; requester i in slice i.
- req_valid  in  NUM_REQUESTERS  per-requester beat valid.
- req_last  in  NUM_REQUESTERS  per-requester last beat of frame.
- req_ready  out  NUM_REQUESTERS  per-requester ready.
- p_enable  out  1  processor enable.
- p_in_data  out  DW  beat data to processor.
- p_in_valid  out  1  beat valid to processor.
- p_in_last  out  1  frame last to processor.
- p_in_ready  in  1  processor ready.
- p_out_data  in  RESULT_WIDTH  processor result.
- p_out_valid  in  1  processor result valid; one-cycle pulse, not backpressurable.
- res_data  out  RESULT_WIDTH  registered result.
- res_id  out  IDW  requester that owns res_data.
- res_error  out  1  result timed out; res_data is zero.
- res_valid  out  1  result valid.
- res_ready  in  1  result consumer ready.
- dropped_results  out  16  saturating count of unexpected p_out_valid pulses.

## Operation
- FSM states: IDLE, STREAM, WAIT_RESULT, DELIVER.
- IDLE: if any req_valid is set, grant the first set bit scanning from rr_ptr upward with wrap. Register grant and go to STREAM. If no req_valid is set, stay.
- STREAM: p_in_data, p_in_valid and p_in_last mux from the granted requester. req_ready[grant] = p_in_ready; all other req_ready bits are 0. On a transfer (valid & ready & last), go to WAIT_RESULT. Non-last beats stay in STREAM.
- WAIT_RESULT: wait_cnt increments each cycle.
  - On p_out_valid, capture p_out_data into res_data, set res_error=0, go to DELIVER.
  - If wait_cnt reaches RESULT_TIMEOUT with no pulse, set res_data=0, res_error=1, go to DELIVER.
  - If p_out_valid and timeout occur in the same cycle, the result wins.
- DELIVER: res_valid=1 and res_id=grant. res_data, res_id and res_error are stable until res_valid & res_ready. On that handshake, set rr_ptr = grant+1 (wrapping to 0 after NUM_REQUESTERS-1) and go to IDLE.
- p_enable = 1 in STREAM and WAIT_RESULT, 0 otherwise.
- A p_out_valid pulse in any state other than WAIT_RESULT increments dropped_results, saturating at 16'hFFFF, and is otherwise ignored.

## Timing
- Reset values: state IDLE, rr_ptr 0, grant 0, wait_cnt 0. All outputs 0: req_ready, p_enable, p_in_valid, p_in_last, p_in_data, res_valid, res_id, res_error, res_data, dropped_results.
- Grant latency: req_valid seen in IDLE in cycle n means STREAM and req_ready are active in cycle n+1.
- Forward path STREAM-to-processor is combinational: zero added latency, full one-beat-per-cycle throughput.
- Result path: p_out_valid in cycle m means res_valid=1 in cycle m+1.
- Back-to-back frames: minimum one IDLE cycle between DELIVER handshake and the next STREAM.
- Reset asserted mid-frame or mid-result: immediate return to the reset state. The partial frame is abandoned; the upstream source must restart it.
- A requester that deasserts req_valid mid-frame stalls STREAM. No timeout applies in STREAM.

## Structure
- Shared package: FSM state encoding (2-bit localparams) and a clog2-based IDW helper function.
- One natural sub-module: rr_priority_picker (NUM_REQUESTERS, request vector + pointer → one-hot grant + index, combinational).
- The processor is instantiated one level up, not inside this block.

## Test plan
- Single requester: req 2 sends 4 beats with last on beat 4; processor pulses result 0xABC 3 cycles later. Expect res_valid with res_id=2, res_data=0xABC, res_error=0; next rr_ptr=3.
- Fairness: all 4 requesters continuously valid with 2-beat frames. Expect grant order 0,1,2,3,0,… and no req_ready ever set for a non-granted requester.
- Backpressure: hold res_ready=0 for 10 cycles in DELIVER. Expect res_data, res_id and res_valid stable, no new grant, and all req_ready=0.
- Timeout: RESULT_TIMEOUT=8 and no p_out_valid. Expect DELIVER with res_error=1 and res_data=0 after 8 WAIT_RESULT cycles. p_out_valid coincident with cycle 8 must yield res_error=0.
- Spurious result: p_out_valid pulsed in IDLE 3 times. Expect dropped_results=3 and res_valid still 0.
- Reset mid-frame: drive reset low during beat 2 of a frame. Expect all outputs 0 immediately. After release, the same requester is re-granted from IDLE with rr_ptr=0.
